ins_fetcher: RTL and testbench

//  Holds the PC and fetches one 32-bit instruction at a time from ICache over the IFIC/ICIF handshake.

---
 rtl/if_pkg.sv | 39 +++
 rtl/ins_queue.sv | 72 +++++++
 rtl/ins_fetcher.sv | 197 +++++++++++++++++++
 tb/tb_ins_fetcher.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetcher: opcodes, BHT counter
// encodings, fetch FSM states and the instruction-queue entry layout.
package if_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_cnt_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
    logic            pred;
  } iq_entry_t;

  function automatic logic [1:0] bht_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != BHT_ST)
      res = cnt + 2'd1;
    else if (!taken && cnt != BHT_SNT)
      res = cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/ins_queue.sv
// Circular FIFO between fetch and decode. Pointers wrap naturally at the
// power-of-two depth; clr empties the queue in one cycle.
module ins_queue
  import if_pkg::*;
#(
  parameter int IQ_WIDTH = 3
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  logic      clr,
  input  logic      push,
  input  iq_entry_t push_data,
  input  logic      pop,
  output iq_entry_t head_data,
  output logic      empty,
  output logic      full
);

  localparam int                DEPTH   = 1 << IQ_WIDTH;
  localparam logic [IQ_WIDTH:0] CNT_MAX = (IQ_WIDTH + 1)'(DEPTH);
  localparam logic [IQ_WIDTH:0] CNT_ONE = (IQ_WIDTH + 1)'(1);
  localparam logic [IQ_WIDTH-1:0] PTR_ONE = IQ_WIDTH'(1);

  logic [IQ_WIDTH-1:0] head_q, head_d;
  logic [IQ_WIDTH-1:0] tail_q, tail_d;
  logic [IQ_WIDTH:0]   count_q, count_d;
  iq_entry_t           mem_q [DEPTH];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (en) begin
      if (clr) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + PTR_ONE;
        if (pop)  head_d = head_q + PTR_ONE;
        if (push && !pop)
          count_d = count_q + CNT_ONE;
        else if (pop && !push)
          count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (en && !clr && push)
      mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_MAX);

endmodule

// File: rtl/ins_fetcher.sv
// Fetch unit: PC register, single-outstanding ICache request FSM, predecode
// with a 2-bit BHT, and an instruction queue feeding the decoder.
module ins_fetcher
  import if_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BHT_WIDTH  = 8,
  parameter int                    IQ_WIDTH   = 3,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  output logic                  IFIC_en,
  output logic [ADDR_WIDTH-1:0] IFIC_addr,
  input  logic                  ICIF_en,
  input  logic [31:0]           ICIF_data,
  input  logic                  DCIF_ask,
  output logic                  IFDC_en,
  output logic [31:0]           IFDC_ins,
  output logic [ADDR_WIDTH-1:0] IFDC_pc,
  output logic                  IFDC_pred_jump,
  input  logic                  RoBIF_jump_en,
  input  logic [ADDR_WIDTH-1:0] RoBIF_jump_addr,
  input  logic                  RoBIF_br_en,
  input  logic [ADDR_WIDTH-1:0] RoBIF_br_pc,
  input  logic                  RoBIF_br_taken,
  output if_state_e             dbg_state
);

  localparam int BHT_ENTRIES = 1 << BHT_WIDTH;

  if_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  ific_en_q, ific_en_d;
  logic [ADDR_WIDTH-1:0] ific_addr_q, ific_addr_d;
  logic                  stale_q, stale_d;
  logic                  ifdc_en_q, ifdc_en_d;
  logic [31:0]           ifdc_ins_q, ifdc_ins_d;
  logic [ADDR_WIDTH-1:0] ifdc_pc_q, ifdc_pc_d;
  logic                  ifdc_pred_q, ifdc_pred_d;
  logic [1:0]            bht_q [BHT_ENTRIES];

  logic                  accept, pop, iq_empty, iq_full;
  iq_entry_t             push_entry, head_entry;
  logic [ADDR_WIDTH-1:0] npc, imm_j, imm_b;
  logic                  pred;
  logic [BHT_WIDTH-1:0]  look_idx, train_idx;
  logic                  unused_br_pc_bits;

  assign unused_br_pc_bits = ^{RoBIF_br_pc[ADDR_WIDTH-1:BHT_WIDTH+2], RoBIF_br_pc[1:0]};
  assign look_idx  = pc_q[BHT_WIDTH+1:2];
  assign train_idx = RoBIF_br_pc[BHT_WIDTH+1:2];

  assign imm_j = {{11{ICIF_data[31]}}, ICIF_data[31], ICIF_data[19:12], ICIF_data[20],
                  ICIF_data[30:21], 1'b0};
  assign imm_b = {{19{ICIF_data[31]}}, ICIF_data[31], ICIF_data[7], ICIF_data[30:25],
                  ICIF_data[11:8], 1'b0};

  // Predecode. pc_q equals IFIC_addr whenever a response is accepted.
  always_comb begin
    npc  = pc_q + 32'd4;
    pred = 1'b0;
    case (ICIF_data[6:0])
      OPC_JAL: begin
        npc  = pc_q + imm_j;
        pred = 1'b1;
      end
      OPC_BRANCH: begin
        if (bht_q[look_idx][1]) begin
          npc  = pc_q + imm_b;
          pred = 1'b1;
        end
      end
      OPC_JALR: npc = pc_q + 32'd4;
      default:  npc = pc_q + 32'd4;
    endcase
  end

  assign push_entry = '{ins: ICIF_data, pc: ific_addr_q, pred: pred};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ific_en_d   = ific_en_q;
    ific_addr_d = ific_addr_q;
    stale_d     = stale_q;
    ifdc_en_d   = ifdc_en_q;
    ifdc_ins_d  = ifdc_ins_q;
    ifdc_pc_d   = ifdc_pc_q;
    ifdc_pred_d = ifdc_pred_q;
    accept      = 1'b0;
    pop         = 1'b0;
    if (Sys_rdy) begin
      if (RoBIF_jump_en) begin
        pc_d      = RoBIF_jump_addr;
        ifdc_en_d = 1'b0;
        if (state_q == WAIT) begin
          if (ICIF_en) begin
            ific_en_d = 1'b0;
            state_d   = IDLE;
            stale_d   = 1'b0;
          end else begin
            stale_d = 1'b1;
          end
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (!iq_full) begin
              ific_en_d   = 1'b1;
              ific_addr_d = pc_q;
              state_d     = WAIT;
            end
          end
          WAIT: begin
            if (ICIF_en) begin
              ific_en_d = 1'b0;
              state_d   = IDLE;
              if (stale_q) begin
                stale_d = 1'b0;
              end else begin
                accept = 1'b1;
                pc_d   = npc;
              end
            end
          end
          default: state_d = IDLE;
        endcase
        if (DCIF_ask && !iq_empty) begin
          pop         = 1'b1;
          ifdc_en_d   = 1'b1;
          ifdc_ins_d  = head_entry.ins;
          ifdc_pc_d   = head_entry.pc;
          ifdc_pred_d = head_entry.pred;
        end else begin
          ifdc_en_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ific_en_q   <= 1'b0;
      ific_addr_q <= '0;
      stale_q     <= 1'b0;
      ifdc_en_q   <= 1'b0;
      ifdc_ins_q  <= '0;
      ifdc_pc_q   <= '0;
      ifdc_pred_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ific_en_q   <= ific_en_d;
      ific_addr_q <= ific_addr_d;
      stale_q     <= stale_d;
      ifdc_en_q   <= ifdc_en_d;
      ifdc_ins_q  <= ifdc_ins_d;
      ifdc_pc_q   <= ifdc_pc_d;
      ifdc_pred_q <= ifdc_pred_d;
    end
  end

  // Training writes at the edge, so a same-cycle lookup sees the old counter.
  always_ff @(posedge Sys_clk or negedge Sys_rst) begin
    if (!Sys_rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_WNT;
    end else if (Sys_rdy && RoBIF_br_en) begin
      bht_q[train_idx] <= bht_update(bht_q[train_idx], RoBIF_br_taken);
    end
  end

  ins_queue #(.IQ_WIDTH(IQ_WIDTH)) u_queue (
    .clk       (Sys_clk),
    .rst_n     (Sys_rst),
    .en        (Sys_rdy),
    .clr       (RoBIF_jump_en),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (iq_empty),
    .full      (iq_full)
  );

  assign IFIC_en        = ific_en_q;
  assign IFIC_addr      = ific_addr_q;
  assign IFDC_en        = ifdc_en_q;
  assign IFDC_ins       = ifdc_ins_q;
  assign IFDC_pc        = ifdc_pc_q;
  assign IFDC_pred_jump = ifdc_pred_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher: straight-line fetch, JAL, BHT-driven
// branches, full queue, flushes, freeze and asynchronous reset.
module tb_ins_fetcher;
  import if_pkg::*;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst = 1'b0;
  logic        Sys_rdy = 1'b1;
  logic        IFIC_en;
  logic [31:0] IFIC_addr;
  logic        ICIF_en = 1'b0;
  logic [31:0] ICIF_data = '0;
  logic        DCIF_ask = 1'b1;
  logic        IFDC_en;
  logic [31:0] IFDC_ins;
  logic [31:0] IFDC_pc;
  logic        IFDC_pred_jump;
  logic        RoBIF_jump_en = 1'b0;
  logic [31:0] RoBIF_jump_addr = '0;
  logic        RoBIF_br_en = 1'b0;
  logic [31:0] RoBIF_br_pc = '0;
  logic        RoBIF_br_taken = 1'b0;
  if_state_e   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] obs_pc_q[$];
  logic [31:0] obs_ins_q[$];
  logic [31:0] obs_pred_q[$];

  localparam logic [31:0] JAL16 = 32'h0100006F;
  localparam logic [31:0] JAL32 = 32'h0200006F;
  localparam logic [31:0] BEQM8 = 32'hFE000CE3;
  localparam logic [31:0] NOP   = 32'h00000013;

  ins_fetcher dut (
    .Sys_clk         (Sys_clk),
    .Sys_rst         (Sys_rst),
    .Sys_rdy         (Sys_rdy),
    .IFIC_en         (IFIC_en),
    .IFIC_addr       (IFIC_addr),
    .ICIF_en         (ICIF_en),
    .ICIF_data       (ICIF_data),
    .DCIF_ask        (DCIF_ask),
    .IFDC_en         (IFDC_en),
    .IFDC_ins        (IFDC_ins),
    .IFDC_pc         (IFDC_pc),
    .IFDC_pred_jump  (IFDC_pred_jump),
    .RoBIF_jump_en   (RoBIF_jump_en),
    .RoBIF_jump_addr (RoBIF_jump_addr),
    .RoBIF_br_en     (RoBIF_br_en),
    .RoBIF_br_pc     (RoBIF_br_pc),
    .RoBIF_br_taken  (RoBIF_br_taken),
    .dbg_state       (dbg_state)
  );

  always #5 Sys_clk = ~Sys_clk;

  // Record every instruction handed to the decoder.
  always @(negedge Sys_clk) begin
    if (Sys_rst && IFDC_en) begin
      obs_pc_q.push_back(IFDC_pc);
      obs_ins_q.push_back(IFDC_ins);
      obs_pred_q.push_back(32'(IFDC_pred_jump));
    end
  end

  task automatic step();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    while (!IFIC_en && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req"}, 32'(IFIC_en), 32'd1);
    check({tag, "_addr"}, IFIC_addr, exp_addr);
  endtask

  task automatic respond(input logic [31:0] data);
    step();
    ICIF_en   = 1'b1;
    ICIF_data = data;
    step();
    ICIF_en   = 1'b0;
  endtask

  task automatic train(input logic [31:0] pc, input logic taken);
    RoBIF_br_en    = 1'b1;
    RoBIF_br_pc    = pc;
    RoBIF_br_taken = taken;
    step();
    RoBIF_br_en    = 1'b0;
  endtask

  task automatic jump(input logic [31:0] addr);
    RoBIF_jump_en   = 1'b1;
    RoBIF_jump_addr = addr;
    step();
    RoBIF_jump_en   = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic pred);
    int n = 0;
    while (obs_pc_q.size() == 0 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_avail"}, 32'(obs_pc_q.size() != 0), 32'd1);
    if (obs_pc_q.size() != 0) begin
      check({tag, "_pc"}, obs_pc_q.pop_front(), pc);
      check({tag, "_ins"}, obs_ins_q.pop_front(), ins);
      check({tag, "_pred"}, obs_pred_q.pop_front(), 32'(pred));
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_ific_en", 32'(IFIC_en), 32'd0);
    check("rst_ific_addr", IFIC_addr, 32'd0);
    check("rst_ifdc_en", 32'(IFDC_en), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    Sys_rst = 1'b1;

    // 1. Straight-line fetch
    for (int k = 0; k < 4; k++) begin
      wait_req("seq", 32'(k * 4));
      respond(32'h00000013 | (32'(k + 1) << 20));
    end
    for (int k = 0; k < 4; k++)
      check_out("seq_out", 32'(k * 4), 32'h00000013 | (32'(k + 1) << 20), 1'b0);

    // 2. JAL at 0x10 jumps to 0x20
    wait_req("jal", 32'h10);
    respond(JAL16);
    wait_req("jal_tgt", 32'h20);
    check_out("jal_out", 32'h10, JAL16, 1'b1);

    // 3. BHT: train 0x40 taken twice, then JAL at 0x20 lands on the branch
    train(32'h40, 1'b1);
    train(32'h40, 1'b1);
    respond(JAL32);
    check_out("jal2_out", 32'h20, JAL32, 1'b1);
    wait_req("br_t", 32'h40);
    respond(BEQM8);
    wait_req("br_t_tgt", 32'h38);
    check_out("br_t_out", 32'h40, BEQM8, 1'b1);
    train(32'h40, 1'b0);
    train(32'h40, 1'b0);
    respond(NOP);
    wait_req("br_3c", 32'h3C);
    respond(NOP);
    wait_req("br_nt", 32'h40);
    respond(BEQM8);
    wait_req("br_nt_tgt", 32'h44);
    check_out("o38", 32'h38, NOP, 1'b0);
    check_out("o3c", 32'h3C, NOP, 1'b0);
    check_out("br_nt_out", 32'h40, BEQM8, 1'b0);

    // 4. Full queue
    DCIF_ask = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) wait_req("fill", 32'h44 + 32'(k * 4));
      respond(NOP);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      check("full_no_req", 32'(IFIC_en), 32'd0);
    end
    check("full_state", 32'(dbg_state), 32'(IDLE));
    DCIF_ask = 1'b1;
    step();
    DCIF_ask = 1'b0;
    wait_req("one_more", 32'h64);
    respond(NOP);
    for (int k = 0; k < 4; k++) begin
      step();
      check("refull_no_req", 32'(IFIC_en), 32'd0);
    end
    check_out("full_pop", 32'h44, NOP, 1'b0);

    // 5. Flush while waiting: stale response is dropped
    jump(32'h8);
    wait_req("pre_flush", 32'h8);
    DCIF_ask = 1'b1;
    jump(32'h100);
    check("flush_ifdc_low", 32'(IFDC_en), 32'd0);
    check("flush_hold_en", 32'(IFIC_en), 32'd1);
    check("flush_hold_addr", IFIC_addr, 32'h8);
    respond(JAL16);
    wait_req("post_flush", 32'h100);
    check("flush_empty", 32'(obs_pc_q.size()), 32'd0);
    DCIF_ask = 1'b0;
    respond(32'h00B00013);
    wait_req("after_100", 32'h104);

    // 6. Response, flush and decoder ask in the same cycle
    DCIF_ask        = 1'b1;
    ICIF_en         = 1'b1;
    ICIF_data       = JAL16;
    RoBIF_jump_en   = 1'b1;
    RoBIF_jump_addr = 32'h200;
    step();
    ICIF_en         = 1'b0;
    RoBIF_jump_en   = 1'b0;
    check("sim_ifdc_low", 32'(IFDC_en), 32'd0);
    check("sim_state", 32'(dbg_state), 32'(IDLE));
    check("sim_ific_low", 32'(IFIC_en), 32'd0);
    wait_req("sim_redirect", 32'h200);
    check("sim_no_pop", 32'(obs_pc_q.size()), 32'd0);

    // Freeze: a response during Sys_rdy=0 is ignored
    Sys_rdy   = 1'b0;
    ICIF_en   = 1'b1;
    ICIF_data = NOP;
    step();
    step();
    step();
    ICIF_en = 1'b0;
    Sys_rdy = 1'b1;
    check("frz_state", 32'(dbg_state), 32'(WAIT));
    check("frz_ific_en", 32'(IFIC_en), 32'd1);
    check("frz_ific_addr", IFIC_addr, 32'h200);
    respond(32'h00A00013);
    check_out("o200", 32'h200, 32'h00A00013, 1'b0);
    wait_req("after_200", 32'h204);

    // Asynchronous reset mid-WAIT
    Sys_rst = 1'b0;
    #1;
    check("arst_ific_en", 32'(IFIC_en), 32'd0);
    check("arst_ific_addr", IFIC_addr, 32'd0);
    check("arst_ifdc_en", 32'(IFDC_en), 32'd0);
    check("arst_ifdc_ins", IFDC_ins, 32'd0);
    check("arst_ifdc_pc", IFDC_pc, 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    step();
    step();
    Sys_rst   = 1'b1;
    ICIF_en   = 1'b1;
    ICIF_data = JAL16;
    step();
    ICIF_en = 1'b0;
    check("rel_state", 32'(dbg_state), 32'(WAIT));
    check("rel_ific_en", 32'(IFIC_en), 32'd1);
    check("rel_ific_addr", IFIC_addr, 32'd0);
    step();
    step();
    check("rel_still_wait", 32'(dbg_state), 32'(WAIT));
    respond(NOP);
    check_out("rel_out", 32'd0, NOP, 1'b0);
    wait_req("rel_next", 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
